// File: rtl/mem_responder_pkg.sv
// Shared bus constants for the 2-bit serial CPU<->memory link.
// The CPU-side transmitter uses the same symbol values.
package mem_responder_pkg;

  localparam logic [1:0] BUS_IDLE      = 2'b00;
  localparam logic [1:0] BUS_HDR_READ  = 2'b01;
  localparam logic [1:0] BUS_HDR_WRITE = 2'b10;
  localparam logic [1:0] BUS_HDR_RSVD  = 2'b11;
  localparam logic [1:0] BUS_REPLY_SB  = 2'b01;

endpackage

// File: rtl/mem_responder_shreg.sv
// Serial shift register: symbol shift-in at the MSB end,
// shift-out from the LSB end, plus parallel load.
module serial_shreg #(
  parameter int W      = 16,
  parameter int NSHIFT = 2,
  parameter int OUT_W  = W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [W-1:0]      i_din,
  input  logic [NSHIFT-1:0] i_sin,
  output logic [OUT_W-1:0]  o_q
);

  logic [W-1:0] r_q;

  // load wins over shift; shift moves one symbol towards the LSB
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_din;
    end else if (i_shift) begin
      r_q <= {i_sin, r_q[W-1:NSHIFT]};
    end
  end

  assign o_q = r_q[OUT_W-1:0];

endmodule

// File: rtl/mem_responder.sv
// Memory-side peer of the CPU serial bus: deserializes read/write
// commands, drives a synchronous memory port, serializes read replies.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int NSHIFT         = 2,
  parameter int PAYLOAD_CYCLES = 8,
  parameter int REPLY_DELAY    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSHIFT-1:0] tx_pins,
  output logic [NSHIFT-1:0] rx_pins,
  output logic [15:0]       mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              busy,
  output logic              protocol_error
);

  localparam int W   = 16;
  localparam int AW  = W - NSHIFT;
  localparam int WCW = $clog2(REPLY_DELAY + 1);

  localparam logic [2:0]     LAST  = 3'(PAYLOAD_CYCLES - 1);
  localparam logic [WCW-1:0] W_CAP = WCW'(1);
  localparam logic [WCW-1:0] W_END = WCW'(REPLY_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WRITE,
    S_WAIT,
    S_REPLY_SB,
    S_REPLY
  } state_t;

  state_t r_state;
  state_t w_nstate;

  logic [2:0]        r_cnt;
  logic [WCW-1:0]    r_wcnt;
  logic              r_is_wr;
  logic [NSHIFT-1:0] r_rx;
  logic              r_re;
  logic              r_we;
  logic [15:0]       r_addr;
  logic [15:0]       r_wdata;
  logic              r_perr;

  logic              w_cnt_inc;
  logic              w_op_ld;
  logic              w_ash;
  logic              w_rld;
  logic              w_rsh;
  logic [NSHIFT-1:0] w_rx_nxt;
  logic              w_re_nxt;
  logic              w_we_nxt;
  logic              w_addr_ld;
  logic              w_wd_ld;
  logic              w_perr_nxt;
  logic              w_tx_act;
  logic              w_last;
  logic [AW-1:0]     w_aq;
  logic [W-1:0]      w_sh_next;
  logic [NSHIFT-1:0] w_rsym;

  // Only 7 symbols need storing: the 8th is taken straight off the pins.
  serial_shreg #(.W(AW), .NSHIFT(NSHIFT)) u_cmd_sh (
    .clk     (clk),
    .reset   (reset),
    .i_load  (1'b0),
    .i_shift (w_ash),
    .i_din   ('0),
    .i_sin   (tx_pins),
    .o_q     (w_aq)
  );

  serial_shreg #(.W(W), .NSHIFT(NSHIFT), .OUT_W(NSHIFT)) u_rep_sh (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_rld),
    .i_shift (w_rsh),
    .i_din   (mem_rdata),
    .i_sin   (BUS_IDLE),
    .o_q     (w_rsym)
  );

  assign w_sh_next = {tx_pins, w_aq};
  assign w_tx_act  = (tx_pins != BUS_IDLE);
  assign w_last    = (r_cnt == LAST);

  // next-state and per-cycle control decode
  always_comb begin
    w_nstate   = r_state;
    w_cnt_inc  = 1'b0;
    w_op_ld    = 1'b0;
    w_ash      = 1'b0;
    w_rld      = 1'b0;
    w_rsh      = 1'b0;
    w_rx_nxt   = BUS_IDLE;
    w_re_nxt   = 1'b0;
    w_we_nxt   = 1'b0;
    w_addr_ld  = 1'b0;
    w_wd_ld    = 1'b0;
    w_perr_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (tx_pins == BUS_HDR_READ ||
            tx_pins == BUS_HDR_WRITE) begin
          w_op_ld  = 1'b1;
          w_nstate = S_ADDR;
        end else if (tx_pins == BUS_HDR_RSVD) begin
          w_perr_nxt = 1'b1;
        end
      end
      S_ADDR: begin
        w_ash     = 1'b1;
        w_cnt_inc = 1'b1;
        if (w_last) begin
          w_addr_ld = 1'b1;
          w_re_nxt  = !r_is_wr;
          w_nstate  = r_is_wr ? S_WDATA : S_WAIT;
        end
      end
      S_WDATA: begin
        w_ash     = 1'b1;
        w_cnt_inc = 1'b1;
        if (w_last) begin
          w_wd_ld  = 1'b1;
          w_we_nxt = 1'b1;
          w_nstate = S_WRITE;
        end
      end
      S_WRITE: begin
        w_perr_nxt = w_tx_act;
        w_nstate   = S_IDLE;
      end
      S_WAIT: begin
        w_perr_nxt = w_tx_act;
        w_rld      = (r_wcnt == W_CAP);
        if (r_wcnt == W_END) begin
          w_rx_nxt = BUS_REPLY_SB;
          w_nstate = S_REPLY_SB;
        end
      end
      S_REPLY_SB: begin
        w_perr_nxt = w_tx_act;
        w_rx_nxt   = w_rsym;
        w_rsh      = 1'b1;
        w_nstate   = S_REPLY;
      end
      S_REPLY: begin
        w_perr_nxt = w_tx_act;
        w_cnt_inc  = 1'b1;
        if (w_last) begin
          w_nstate = S_IDLE;
        end else begin
          w_rx_nxt = w_rsym;
          w_rsh    = 1'b1;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wcnt  <= '0;
      r_is_wr <= 1'b0;
      r_rx    <= BUS_IDLE;
      r_re    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_cnt_inc ? r_cnt + 3'd1 : r_cnt;
      r_wcnt  <= (r_state == S_WAIT) ? r_wcnt + WCW'(1) : '0;
      if (w_op_ld) begin
        r_is_wr <= (tx_pins == BUS_HDR_WRITE);
      end
      r_rx   <= w_rx_nxt;
      r_re   <= w_re_nxt;
      r_we   <= w_we_nxt;
      r_perr <= w_perr_nxt;
      if (w_addr_ld) begin
        r_addr <= w_sh_next;
      end
      if (w_wd_ld) begin
        r_wdata <= w_sh_next;
      end
    end
  end

  assign rx_pins        = r_rx;
  assign mem_addr       = r_addr;
  assign mem_re         = r_re;
  assign mem_we         = r_we;
  assign mem_wdata      = r_wdata;
  assign protocol_error = r_perr;
  assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: per-cycle expectations are
// built from the bus timing rules and compared against two DUTs.
module tb_mem_responder;

  localparam int N = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst2, rst5;
  logic [1:0]  tx2, tx5, rx2, rx5;
  logic [15:0] a2, a5, wd2, wd5;
  logic [15:0] rd2 = '0;
  logic [15:0] rd5 = '0;
  logic        re2, re5, we2, we5, busy2, busy5, perr2, perr5;

  mem_responder #(.REPLY_DELAY(2)) u_d2 (
    .clk(clk), .reset(rst2), .tx_pins(tx2), .rx_pins(rx2),
    .mem_addr(a2), .mem_re(re2), .mem_we(we2), .mem_wdata(wd2),
    .mem_rdata(rd2), .busy(busy2), .protocol_error(perr2)
  );

  mem_responder #(.REPLY_DELAY(5)) u_d5 (
    .clk(clk), .reset(rst5), .tx_pins(tx5), .rx_pins(rx5),
    .mem_addr(a5), .mem_re(re5), .mem_we(we5), .mem_wdata(wd5),
    .mem_rdata(rd5), .busy(busy5), .protocol_error(perr5)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] mem[int];
  logic [15:0] ref_mem[int];

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return 16'(int'(a) * 40503) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] mem_get(input logic [15:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : dflt(a);
  endfunction

  function automatic logic [15:0] ref_get(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  // behavioural synchronous memory behind both DUTs
  always @(posedge clk) begin
    if (re2) rd2 <= mem_get(a2);
    if (re5) rd5 <= mem_get(a5);
    if (we2) mem[int'(a2)] = wd2;
    if (we5) mem[int'(a5)] = wd5;
  end

  bit          sel;
  logic [1:0]  stim[N];
  bit          srst[N];
  logic [1:0]  exp_rx[N];
  bit          exp_re[N], exp_we[N], exp_busy[N], exp_perr[N];
  logic [15:0] exp_a[N], exp_d[N];
  logic [1:0]  o_rx[N];
  logic        o_re[N], o_we[N], o_busy[N], o_perr[N];
  logic [15:0] o_a[N], o_d[N];

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      stim[i] = 2'b00; srst[i] = 1'b0; exp_rx[i] = 2'b00;
      exp_re[i] = 0; exp_we[i] = 0; exp_busy[i] = 0; exp_perr[i] = 0;
      exp_a[i] = '0; exp_d[i] = '0;
    end
  endtask

  task automatic model_read(input int t0, input int d, input logic [15:0] a);
    logic [15:0] v;
    v = ref_get(a);
    stim[t0] = 2'b01;
    for (int k = 0; k < 8; k++) stim[t0+1+k] = a[2*k +: 2];
    for (int t = t0 + 1; t <= t0 + 17 + d; t++) exp_busy[t] = 1;
    exp_re[t0+9] = 1;
    exp_a[t0+9]  = a;
    exp_rx[t0+9+d] = 2'b01;
    for (int k = 0; k < 8; k++) exp_rx[t0+10+d+k] = v[2*k +: 2];
  endtask

  task automatic model_write(input int t0, input logic [15:0] a,
                             input logic [15:0] v);
    stim[t0] = 2'b10;
    for (int k = 0; k < 8; k++) begin
      stim[t0+1+k] = a[2*k +: 2];
      stim[t0+9+k] = v[2*k +: 2];
    end
    for (int t = t0 + 1; t <= t0 + 17; t++) exp_busy[t] = 1;
    exp_we[t0+17] = 1;
    exp_a[t0+17]  = a;
    exp_d[t0+17]  = v;
    ref_mem[int'(a)] = v;
  endtask

  task automatic run(input int n);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      o_rx[t]   = sel ? rx5 : rx2;
      o_re[t]   = sel ? re5 : re2;
      o_we[t]   = sel ? we5 : we2;
      o_busy[t] = sel ? busy5 : busy2;
      o_perr[t] = sel ? perr5 : perr2;
      o_a[t]    = sel ? a5 : a2;
      o_d[t]    = sel ? wd5 : wd2;
      if (sel) begin tx5 = stim[t]; rst5 = srst[t]; end
      else     begin tx2 = stim[t]; rst2 = srst[t]; end
    end
    @(negedge clk);
    tx2 = 2'b00; tx5 = 2'b00; rst2 = 1'b0; rst5 = 1'b0;
  endtask

  task automatic test_reset();
    rst2 = 1; rst5 = 1; tx2 = 0; tx5 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rx2, re2, we2, busy2, perr2, a2, wd2} !== 38'b0) begin
      errors++;
      $display("FAIL reset_d2 got=%h exp=0", {rx2, re2, we2, busy2, perr2, a2, wd2});
    end
    checks++;
    if ({rx5, re5, we5, busy5, perr5, a5, wd5} !== 38'b0) begin
      errors++;
      $display("FAIL reset_d5 got=%h exp=0", {rx5, re5, we5, busy5, perr5, a5, wd5});
    end
    rst2 = 0; rst5 = 0;
    @(negedge clk);
  endtask

  task automatic test_read_basic();
    int n;
    clear_model(); sel = 0; n = 24;
    mem[16'h1234] = 16'hBEEF; ref_mem[16'h1234] = 16'hBEEF;
    model_read(0, 2, 16'h1234);
    run(n);
    for (int t = 0; t < n; t++) begin
      checks++;
      if ({o_rx[t], o_re[t], o_we[t], o_busy[t], o_perr[t]} !==
          {exp_rx[t], exp_re[t], exp_we[t], exp_busy[t], exp_perr[t]}) begin
        errors++;
        $display("FAIL read_basic cyc=%0d rx/re/we/busy/perr got=%b exp=%b", t,
          {o_rx[t], o_re[t], o_we[t], o_busy[t], o_perr[t]},
          {exp_rx[t], exp_re[t], exp_we[t], exp_busy[t], exp_perr[t]});
      end
      if (exp_re[t]) begin
        checks++;
        if (o_a[t] !== exp_a[t]) begin
          errors++;
          $display("FAIL read_basic_addr cyc=%0d got=%h exp=%h", t, o_a[t], exp_a[t]);
        end
      end
    end
  endtask

  task automatic test_write();
    int n;
    clear_model(); sel = 0; n = 42;
    model_write(0, 16'h00FF, 16'hA5C3);
    stim[17] = 2'b10;
    exp_perr[18] = 1;
    model_read(18, 2, 16'h00FF);
    run(n);
    for (int t = 0; t < n; t++) begin
      checks++;
      if ({o_rx[t], o_re[t], o_we[t], o_busy[t], o_perr[t]} !==
          {exp_rx[t], exp_re[t], exp_we[t], exp_busy[t], exp_perr[t]}) begin
        errors++;
        $display("FAIL write cyc=%0d rx/re/we/busy/perr got=%b exp=%b", t,
          {o_rx[t], o_re[t], o_we[t], o_busy[t], o_perr[t]},
          {exp_rx[t], exp_re[t], exp_we[t], exp_busy[t], exp_perr[t]});
      end
      if (exp_re[t] || exp_we[t]) begin
        checks++;
        if (o_a[t] !== exp_a[t]) begin
          errors++;
          $display("FAIL write_addr cyc=%0d got=%h exp=%h", t, o_a[t], exp_a[t]);
        end
      end
      if (exp_we[t]) begin
        checks++;
        if (o_d[t] !== exp_d[t]) begin
          errors++;
          $display("FAIL write_data cyc=%0d got=%h exp=%h", t, o_d[t], exp_d[t]);
        end
      end
    end
  endtask

  task automatic test_reserved();
    int n;
    clear_model(); sel = 0; n = 24;
    stim[0] = 2'b11;
    exp_perr[1] = 1;
    model_read(2, 2, 16'h0000);
    run(n);
    for (int t = 0; t < n; t++) begin
      checks++;
      if ({o_rx[t], o_re[t], o_we[t], o_busy[t], o_perr[t]} !==
          {exp_rx[t], exp_re[t], exp_we[t], exp_busy[t], exp_perr[t]}) begin
        errors++;
        $display("FAIL reserved cyc=%0d rx/re/we/busy/perr got=%b exp=%b", t,
          {o_rx[t], o_re[t], o_we[t], o_busy[t], o_perr[t]},
          {exp_rx[t], exp_re[t], exp_we[t], exp_busy[t], exp_perr[t]});
      end
    end
  endtask

  task automatic test_half_duplex();
    int n;
    logic [15:0] a, b;
    clear_model(); sel = 0; n = 42;
    a = 16'($urandom); b = 16'($urandom);
    model_read(0, 2, a);
    stim[13] = 2'b10;
    exp_perr[14] = 1;
    model_read(20, 2, b);
    run(n);
    for (int t = 0; t < n; t++) begin
      checks++;
      if ({o_rx[t], o_re[t], o_we[t], o_busy[t], o_perr[t]} !==
          {exp_rx[t], exp_re[t], exp_we[t], exp_busy[t], exp_perr[t]}) begin
        errors++;
        $display("FAIL half_duplex cyc=%0d rx/re/we/busy/perr got=%b exp=%b", t,
          {o_rx[t], o_re[t], o_we[t], o_busy[t], o_perr[t]},
          {exp_rx[t], exp_re[t], exp_we[t], exp_busy[t], exp_perr[t]});
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int n;
    logic [15:0] a;
    clear_model(); sel = 0; n = 44;
    a = 16'h3C3C;
    stim[0] = 2'b10;
    for (int k = 0; k < 8; k++) stim[1+k] = a[2*k +: 2];
    for (int k = 0; k < 4; k++) stim[9+k] = 2'b11;
    for (int t = 1; t <= 12; t++) exp_busy[t] = 1;
    srst[12] = 1;
    model_read(20, 2, a);
    run(n);
    for (int t = 0; t < n; t++) begin
      checks++;
      if ({o_rx[t], o_re[t], o_we[t], o_busy[t], o_perr[t]} !==
          {exp_rx[t], exp_re[t], exp_we[t], exp_busy[t], exp_perr[t]}) begin
        errors++;
        $display("FAIL reset_mid_write cyc=%0d rx/re/we/busy/perr got=%b exp=%b", t,
          {o_rx[t], o_re[t], o_we[t], o_busy[t], o_perr[t]},
          {exp_rx[t], exp_re[t], exp_we[t], exp_busy[t], exp_perr[t]});
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, t0;
    logic [15:0] a, v, last;
    clear_model(); sel = 0; t0 = 0; last = 16'h00FF;
    for (int i = 0; i < 8; i++) begin
      a = ($urandom_range(0, 1) == 1) ? last : 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        v = 16'($urandom);
        model_write(t0, a, v);
        last = a;
        t0 += 18;
      end else begin
        model_read(t0, 2, a);
        t0 += 20;
      end
      t0 += $urandom_range(0, 2);
    end
    n = t0 + 2;
    run(n);
    for (int t = 0; t < n; t++) begin
      checks++;
      if ({o_rx[t], o_re[t], o_we[t], o_busy[t], o_perr[t]} !==
          {exp_rx[t], exp_re[t], exp_we[t], exp_busy[t], exp_perr[t]}) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d rx/re/we/busy/perr got=%b exp=%b", t,
          {o_rx[t], o_re[t], o_we[t], o_busy[t], o_perr[t]},
          {exp_rx[t], exp_re[t], exp_we[t], exp_busy[t], exp_perr[t]});
      end
      if (exp_re[t] || exp_we[t]) begin
        checks++;
        if (o_a[t] !== exp_a[t]) begin
          errors++;
          $display("FAIL back_to_back_addr cyc=%0d got=%h exp=%h", t, o_a[t], exp_a[t]);
        end
      end
      if (exp_we[t]) begin
        checks++;
        if (o_d[t] !== exp_d[t]) begin
          errors++;
          $display("FAIL back_to_back_data cyc=%0d got=%h exp=%h", t, o_d[t], exp_d[t]);
        end
      end
    end
  endtask

  task automatic test_delay5();
    int n;
    clear_model(); sel = 1; n = 48;
    model_read(0, 5, 16'h0001);
    model_read(23, 5, 16'h0002);
    run(n);
    for (int t = 0; t < n; t++) begin
      checks++;
      if ({o_rx[t], o_re[t], o_we[t], o_busy[t], o_perr[t]} !==
          {exp_rx[t], exp_re[t], exp_we[t], exp_busy[t], exp_perr[t]}) begin
        errors++;
        $display("FAIL delay5 cyc=%0d rx/re/we/busy/perr got=%b exp=%b", t,
          {o_rx[t], o_re[t], o_we[t], o_busy[t], o_perr[t]},
          {exp_rx[t], exp_re[t], exp_we[t], exp_busy[t], exp_perr[t]});
      end
      if (exp_re[t]) begin
        checks++;
        if (o_a[t] !== exp_a[t]) begin
          errors++;
          $display("FAIL delay5_addr cyc=%0d got=%h exp=%h", t, o_a[t], exp_a[t]);
        end
      end
    end
    sel = 0;
  endtask

  initial begin
    sel = 0;
    tx2 = 0; tx5 = 0; rst2 = 1; rst5 = 1;
    test_reset();
    test_read_basic();
    test_write();
    test_reserved();
    test_half_duplex();
    test_reset_mid_write();
    test_back_to_back();
    test_delay5();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
